// File: rtl/seq_pkg.sv
// Shared types and constants for the bit-stream serializer and the sequence
// detectors it feeds.
package seq_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  // Serial line level while no word is being shifted; the detector benches use it too.
  localparam logic IDLE_BIT_DEFAULT = 1'b0;

  // Bit-counter width for a WIDTH-bit word (at least one bit).
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/ser_hold_reg.sv
// One-entry holding buffer: accepts a word when empty and releases it on pop.
module ser_hold_reg #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] data_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o
);

  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;

  // Accept needs an empty buffer and pop needs a full one, so they never coincide.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (valid_i && !full_q) begin
      full_d = 1'b1;
      data_d = data_i;
    end else if (pop_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign ready_o = ~full_q;
  assign data_o  = data_q;
  assign full_o  = full_q;

endmodule

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in on valid/ready, one bit per
// clock out on x, back-to-back words streamed with no gap bits.
module seq_bit_serializer
  import seq_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = IDLE_BIT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x,
  output logic             x_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int               CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  ser_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] hold_data;
  logic             hold_full;
  logic             at_last;
  logic             load;

  // Handshake: a word transfers on a rising edge where in_valid & in_ready.
  ser_hold_reg #(.W(WIDTH)) u_hold (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .data_i  (in_data),
    .valid_i (in_valid),
    .ready_o (in_ready),
    .pop_i   (load),
    .data_o  (hold_data),
    .full_o  (hold_full)
  );

  assign at_last = (cnt_q == LAST);
  assign load    = hold_full && ((state_q == IDLE) || at_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
    end else if (load) begin
      state_q <= SHIFT;
      cnt_q   <= '0;
      sh_q    <= hold_data;
    end else if (state_q == SHIFT) begin
      if (at_last) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        sh_q    <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
        sh_q  <= MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};
      end
    end
  end

  assign x_valid     = (state_q == SHIFT);
  assign x           = x_valid ? (MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0]) : IDLE_BIT;
  assign frame_start = x_valid && (cnt_q == '0);
  assign busy        = x_valid || hold_full;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer: an MSB-first and an LSB-first instance
// on a shared clock and reset.
module tb_seq_bit_serializer;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready, x, x_valid, frame_start, busy;
  logic [7:0] in_data_l;
  logic       in_valid_l;
  logic       in_ready_l, x_l, x_valid_l, frame_start_l, busy_l;

  int n_cmp;
  int n_fail;
  int cyc;
  int acc_cyc[3];
  logic exp_q[$];

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .x(x), .x_valid(x_valid), .frame_start(frame_start),
    .busy(busy)
  );

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data_l), .in_valid(in_valid_l),
    .in_ready(in_ready_l), .x(x_l), .x_valid(x_valid_l), .frame_start(frame_start_l),
    .busy(busy_l)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(v[i]);
  endtask

  // Producer: presents up to three words back to back, in_valid held high.
  task automatic send_words(input logic [7:0] w0, input logic [7:0] w1,
                            input logic [7:0] w2, input int n);
    logic [7:0] w[3];
    logic rdy;
    bit   got;
    int   c;
    w[0] = w0; w[1] = w1; w[2] = w2;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = w[i];
      got = 1'b0;
      for (int t = 0; t < 40 && !got; t++) begin
        rdy = in_ready;
        c   = cyc;
        @(posedge clk);
        if (rdy) begin
          got = 1'b1;
          acc_cyc[i] = c;
        end
        @(negedge clk);
      end
      if (!got) begin
        n_cmp++; n_fail++;
        $display("FAIL accept_timeout word %0d: got in_ready=0 for 40 cycles, want accept", i);
      end
    end
    in_valid = 1'b0;
  endtask

  // Monitor: waits for the stream, then checks nbits contiguous bits against exp_q.
  task automatic collect(input int nbits, input string name);
    bit started = 1'b0;
    logic e;
    for (int t = 0; t < 30 && !started; t++) begin
      @(negedge clk);
      if (x_valid) started = 1'b1;
    end
    n_cmp++;
    if (!started) begin
      n_fail++;
      $display("FAIL %s_start: got no x_valid within 30 cycles, want stream", name);
    end else begin
      for (int i = 0; i < nbits; i++) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (x_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL %s_xvalid bit %0d: got %b want 1", name, i, x_valid);
        end
        n_cmp++;
        if (x !== e) begin
          n_fail++;
          $display("FAIL %s_x bit %0d: got %b want %b", name, i, x, e);
        end
        n_cmp++;
        if (frame_start !== ((i % 8) == 0)) begin
          n_fail++;
          $display("FAIL %s_frame bit %0d: got %b want %b", name, i, frame_start, (i % 8) == 0);
        end
        @(negedge clk);
      end
      n_cmp++;
      if (x_valid !== 1'b0 || x !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_end: got x_valid=%b x=%b busy=%b want 0 0 0", name, x_valid, x, busy);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_valid_l = 1'b0; in_data_l = '0;
    #2;
    n_cmp++;
    if ({in_ready, x, x_valid, frame_start, busy} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_msb: got rdy,x,xv,fs,busy=%b want 10000",
               {in_ready, x, x_valid, frame_start, busy});
    end
    n_cmp++;
    if ({in_ready_l, x_l, x_valid_l, frame_start_l, busy_l} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_lsb: got rdy,x,xv,fs,busy=%b want 10000",
               {in_ready_l, x_l, x_valid_l, frame_start_l, busy_l});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({in_ready, x, x_valid, busy} !== 4'b1000) begin
        n_fail++;
        $display("FAIL idle cycle %0d: got rdy,x,xv,busy=%b want 1000", i, {in_ready, x, x_valid, busy});
      end
    end
  endtask

  task automatic test_single();
    logic [7:0] pat;
    pat = 8'b11011010;
    in_valid = 1'b1; in_data = 8'hDA;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if ({in_ready, x_valid, busy} !== 3'b001) begin
      n_fail++;
      $display("FAIL single_held: got rdy,xv,busy=%b want 001", {in_ready, x_valid, busy});
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++;
      if (x_valid !== 1'b1 || x !== pat[7 - i] || frame_start !== (i == 0)) begin
        n_fail++;
        $display("FAIL single bit %0d: got xv=%b x=%b fs=%b want 1 %b %b",
                 i, x_valid, x, frame_start, pat[7 - i], i == 0);
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({in_ready, x, x_valid, busy} !== 4'b1000) begin
      n_fail++;
      $display("FAIL single_end: got rdy,x,xv,busy=%b want 1000", {in_ready, x, x_valid, busy});
    end
  endtask

  task automatic test_back_to_back();
    push_bits(32'b1101000000001101, 16);
    fork
      send_words(8'hD0, 8'h0D, 8'h00, 2);
      collect(16, "b2b");
    join
    n_cmp++;
    if (acc_cyc[1] - acc_cyc[0] !== 2) begin
      n_fail++;
      $display("FAIL b2b_accept_gap: got %0d want 2", acc_cyc[1] - acc_cyc[0]);
    end
  endtask

  task automatic test_backpressure();
    push_bits(32'b101001010011110011110000, 24);
    fork
      send_words(8'hA5, 8'h3C, 8'hF0, 3);
      collect(24, "bp");
    join
    n_cmp++;
    if (acc_cyc[1] - acc_cyc[0] !== 2) begin
      n_fail++;
      $display("FAIL bp_accept01: got %0d want 2", acc_cyc[1] - acc_cyc[0]);
    end
    n_cmp++;
    if (acc_cyc[2] - acc_cyc[1] !== 8) begin
      n_fail++;
      $display("FAIL bp_accept12: got %0d want 8", acc_cyc[2] - acc_cyc[1]);
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] pat;
    pat = 8'b10110000;
    in_valid_l = 1'b1; in_data_l = 8'hB0;
    @(negedge clk);
    in_valid_l = 1'b0;
    n_cmp++;
    if (x_valid_l !== 1'b0) begin
      n_fail++;
      $display("FAIL lsb_latency: got xv=%b want 0", x_valid_l);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++;
      if (x_valid_l !== 1'b1 || x_l !== pat[i] || frame_start_l !== (i == 0)) begin
        n_fail++;
        $display("FAIL lsb bit %0d: got xv=%b x=%b fs=%b want 1 %b %b",
                 i, x_valid_l, x_l, frame_start_l, pat[i], i == 0);
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({x_l, x_valid_l, busy_l} !== 3'b000) begin
      n_fail++;
      $display("FAIL lsb_end: got x,xv,busy=%b want 000", {x_l, x_valid_l, busy_l});
    end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_data = 8'hFF;
    @(negedge clk);
    in_data = 8'h55;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if ({in_ready, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL mid_held: got rdy,busy=%b want 01", {in_ready, busy});
    end
    @(negedge clk);
    n_cmp++;
    if ({x_valid, x} !== 2'b11) begin
      n_fail++;
      $display("FAIL mid_shifting: got xv,x=%b want 11", {x_valid, x});
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, x, x_valid, frame_start, busy} !== 5'b10000) begin
      n_fail++;
      $display("FAIL mid_async_reset: got rdy,x,xv,fs,busy=%b want 10000",
               {in_ready, x, x_valid, frame_start, busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({in_ready, x, x_valid, busy} !== 4'b1000) begin
        n_fail++;
        $display("FAIL mid_after cycle %0d: got rdy,x,xv,busy=%b want 1000",
                 i, {in_ready, x, x_valid, busy});
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    cyc = 0;
    test_reset();
    test_idle();
    test_single();
    test_back_to_back();
    @(negedge clk);
    test_backpressure();
    @(negedge clk);
    test_lsb_first();
    @(negedge clk);
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
